term_write_arbiter: RTL and testbench
=====================================

TERM_WRITE_ARBITER -- requirements
Module: term_write_arbiter

Interface
REQ-001 Parameter COLS, default 80, number of character columns; valid h is 0..COLS-1.
REQ-002 Parameter ROWS, default 60, number of character rows; valid v is 0..ROWS-1.
REQ-003 Reset is rst, synchronous, active-high; clock is clk.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1,2) has a beat; held until accepted.
REQ-007 reqN_h  in  8  beat column.
REQ-008 reqN_v  in  8  beat row.
REQ-009 reqN_char  in  6  beat character code; space = 0.
REQ-010 reqN_last  in  1  beat ends requester's burst.
REQ-011 reqN_ready  out  1  beat accepted this cycle when reqN_valid and reqN_ready are both high.
REQ-012 clear_req  in  1  single-cycle pulse requesting full-screen blank.
REQ-013 w_h_addr  out  8  character-buffer write column.
REQ-014 w_v_addr  out  8  character-buffer write row.
REQ-015 w_data  out  6  character-buffer write data.
REQ-016 w_en  out  1  character-buffer write strobe.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 clear_done  out  1  one-cycle pulse when screen blank completes.
REQ-019 err_oob  out  1  sticky out-of-range beat flag.

Function
REQ-020 States SHALL be IDLE, BURST, CLEAR; one write slot per cycle shared by requesters and clear engine.
REQ-021 clear_req in any state SHALL set clear_pending; a second clear_req while pending or in CLEAR SHALL be absorbed (no extra clear).
REQ-022 IDLE: clear_pending -> CLEAR (clear_pending cleared); else req0_valid -> BURST grant 0; else req1/req2 valid -> BURST, choosing by round-robin pointer rr when both valid; else stay.
REQ-023 Grant decision SHALL take one cycle; reqN_ready SHALL be high only in BURST for the granted N, combinational from state and grant.
REQ-024 In BURST, an accepted beat with reqN_last=1 SHALL return to IDLE next cycle; a burst SHALL never be preempted, including by req0 or clear_req.
REQ-025 On completion of a grant-1 burst rr SHALL point to 2; grant-2 burst -> rr points to 1; grant-0 bursts SHALL not change rr.
REQ-026 Accepted in-range beat SHALL produce w_en=1 with w_h_addr/w_v_addr/w_data equal to the beat fields exactly one cycle later (registered outputs).
REQ-027 Accepted beat with h>=COLS or v>=ROWS SHALL be consumed (ready high, last honoured), SHALL produce no w_en, and SHALL set err_oob.
REQ-028 CLEAR: write w_data=0 to every cell, row-major (h increments, wraps to 0 at COLS-1 with v+1), one write per cycle, starting (0,0), ending (COLS-1,ROWS-1); exactly COLS*ROWS w_en pulses.
REQ-029 Cycle after final CLEAR write SHALL return to IDLE with clear_done=1 for one cycle; w_en SHALL be 0 that cycle unless otherwise driven (it is not: IDLE grants take one cycle).
REQ-030 w_en SHALL be 0 in every cycle not caused by REQ-026 or REQ-028; address/data outputs hold last value when w_en=0.
REQ-031 Requester valid dropping before acceptance is a protocol violation; behaviour undefined, no checking required.

Reset
REQ-032 On rst: state IDLE, rr=1, clear_pending=0, clear counters 0, w_en=0, w_h_addr=0, w_v_addr=0, w_data=0, clear_done=0, err_oob=0, all reqN_ready=0.
REQ-033 rst mid-BURST or mid-CLEAR SHALL abort immediately; no w_en in the cycle after rst is sampled.
REQ-034 err_oob SHALL clear only on rst.

Verification
REQ-035 req0 burst of 3 beats (0,0,'R'=18),(0,1,18),(0,2,18 last) -> grant cycle, then ready 3 cycles, w_en pulses at (0,0),(0,1),(0,2) data 18 each one cycle after acceptance, then IDLE.
REQ-036 req1 and req2 both valid continuously with 1-beat bursts after reset -> grants alternate 1,2,1,2; asserting req0 mid-req1 burst -> req1 completes, then req0 granted before req2.
REQ-037 COLS=4, ROWS=3, clear_req pulse in IDLE -> 12 consecutive w_en with data 0, addresses (0,0)..(3,2) row-major, clear_done pulse next cycle; second clear_req during CLEAR ignored.
REQ-038 clear_req during req2 4-beat burst -> burst finishes all 4 writes, then CLEAR starts from IDLE next cycle.
REQ-039 req1 beat (COLS,0,5 last) -> ready high, no w_en, err_oob=1 and stays 1 through later bursts until rst.
REQ-040 rst asserted at clear write 5 of 12 -> no further w_en, busy=0, err_oob=0, rr=1 next cycle.

Source files
------------

// File: rtl/term_write_arbiter.sv
// Character-buffer write arbiter for a text terminal.
// Three requesters and a full-screen clear engine share one buffer write slot
// per cycle. req0 has fixed priority over req1/req2, and req1/req2 alternate
// by round-robin. A granted burst is never preempted. A screen clear runs only
// from IDLE and blanks every cell in row-major order.
module term_write_arbiter #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_h,
  input  logic [7:0] req0_v,
  input  logic [5:0] req0_char,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_h,
  input  logic [7:0] req1_v,
  input  logic [5:0] req1_char,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       req2_valid,
  input  logic [7:0] req2_h,
  input  logic [7:0] req2_v,
  input  logic [5:0] req2_char,
  input  logic       req2_last,
  output logic       req2_ready,
  input  logic       clear_req,
  output logic [7:0] w_h_addr,
  output logic [7:0] w_v_addr,
  output logic [5:0] w_data,
  output logic       w_en,
  output logic       busy,
  output logic       clear_done,
  output logic       err_oob
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  // Bounds are widened by one bit so that COLS/ROWS up to 256 still compare correctly.
  localparam logic [8:0] COLS_W = 9'(COLS);
  localparam logic [8:0] ROWS_W = 9'(ROWS);
  localparam logic [7:0] H_LAST = 8'(COLS - 1);
  localparam logic [7:0] V_LAST = 8'(ROWS - 1);

  logic [1:0] r_state;
  logic [1:0] r_grant;
  logic [1:0] r_rr;
  logic       r_clear_pending;
  logic [7:0] r_clr_h;
  logic [7:0] r_clr_v;
  logic       r_clr_fin;
  logic       r_clear_done;
  logic       r_err_oob;
  logic       r_w_en;
  logic [7:0] r_w_h_addr;
  logic [7:0] r_w_v_addr;
  logic [5:0] r_w_data;

  logic       w_sel_valid;
  logic [7:0] w_sel_h;
  logic [7:0] w_sel_v;
  logic [5:0] w_sel_char;
  logic       w_sel_last;
  logic       w_accept;
  logic       w_in_range;
  logic       w_clr_last;

  // Route the granted requester's beat onto a single internal beat bus.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    w_sel_valid = 1'b0;
    w_sel_h     = '0;
    w_sel_v     = '0;
    w_sel_char  = '0;
    w_sel_last  = 1'b0;
    case (r_grant)
      2'd0: begin
        w_sel_valid = req0_valid;
        w_sel_h     = req0_h;
        w_sel_v     = req0_v;
        w_sel_char  = req0_char;
        w_sel_last  = req0_last;
      end
      2'd1: begin
        w_sel_valid = req1_valid;
        w_sel_h     = req1_h;
        w_sel_v     = req1_v;
        w_sel_char  = req1_char;
        w_sel_last  = req1_last;
      end
      2'd2: begin
        w_sel_valid = req2_valid;
        w_sel_h     = req2_h;
        w_sel_v     = req2_v;
        w_sel_char  = req2_char;
        w_sel_last  = req2_last;
      end
      default: ;
    endcase
  end

  assign w_accept   = (r_state == ST_BURST) && w_sel_valid;
  assign w_in_range = ({1'b0, w_sel_h} < COLS_W) && ({1'b0, w_sel_v} < ROWS_W);
  assign w_clr_last = (r_clr_h == H_LAST) && (r_clr_v == V_LAST);

  assign req0_ready = (r_state == ST_BURST) && (r_grant == 2'd0);
  assign req1_ready = (r_state == ST_BURST) && (r_grant == 2'd1);
  assign req2_ready = (r_state == ST_BURST) && (r_grant == 2'd2);

  assign busy       = (r_state != ST_IDLE);
  assign w_en       = r_w_en;
  assign w_h_addr   = r_w_h_addr;
  assign w_v_addr   = r_w_v_addr;
  assign w_data     = r_w_data;
  assign clear_done = r_clear_done;
  assign err_oob    = r_err_oob;

  // State, grant and round-robin pointer: grant from IDLE, release on the last beat.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= 2'd0;
      r_rr    <= 2'd1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_clear_pending) begin
            r_state <= ST_CLEAR;
          end else if (req0_valid) begin
            r_state <= ST_BURST;
            r_grant <= 2'd0;
          end else if (req1_valid && req2_valid) begin
            r_state <= ST_BURST;
            r_grant <= r_rr;
          end else if (req1_valid) begin
            r_state <= ST_BURST;
            r_grant <= 2'd1;
          end else if (req2_valid) begin
            r_state <= ST_BURST;
            r_grant <= 2'd2;
          end
        end
        ST_BURST: begin
          if (w_accept && w_sel_last) begin
            r_state <= ST_IDLE;
            if (r_grant == 2'd1)      r_rr <= 2'd2;
            else if (r_grant == 2'd2) r_rr <= 2'd1;
          end
        end
        ST_CLEAR: begin
          if (w_clr_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Latch a clear request until IDLE can start it; requests during CLEAR are absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clear_pending <= 1'b0;
    end else if ((r_state == ST_IDLE) && r_clear_pending) begin
      r_clear_pending <= 1'b0;
    end else if (clear_req && (r_state != ST_CLEAR)) begin
      r_clear_pending <= 1'b1;
    end
  end

  // Row-major clear cursor; it wraps back to (0,0) as the last cell is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_h <= 8'd0;
      r_clr_v <= 8'd0;
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_h == H_LAST) begin
        r_clr_h <= 8'd0;
        r_clr_v <= (r_clr_v == V_LAST) ? 8'd0 : r_clr_v + 8'd1;
      end else begin
        r_clr_h <= r_clr_h + 8'd1;
      end
    end
  end

  // Registered buffer write port; the address and data hold whenever no write occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_en     <= 1'b0;
      r_w_h_addr <= 8'd0;
      r_w_v_addr <= 8'd0;
      r_w_data   <= 6'd0;
    end else begin
      r_w_en <= 1'b0;
      if (r_state == ST_CLEAR) begin
        r_w_en     <= 1'b1;
        r_w_h_addr <= r_clr_h;
        r_w_v_addr <= r_clr_v;
        r_w_data   <= 6'd0;
      end else if (w_accept && w_in_range) begin
        r_w_en     <= 1'b1;
        r_w_h_addr <= w_sel_h;
        r_w_v_addr <= w_sel_v;
        r_w_data   <= w_sel_char;
      end
    end
  end

  // Clear-done pulse lands the cycle after the final clear write; out-of-range flag is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_fin    <= 1'b0;
      r_clear_done <= 1'b0;
      r_err_oob    <= 1'b0;
    end else begin
      r_clr_fin    <= (r_state == ST_CLEAR) && w_clr_last;
      r_clear_done <= r_clr_fin;
      if (w_accept && !w_in_range) r_err_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_term_write_arbiter.sv
// Self-checking bench for term_write_arbiter (COLS=4, ROWS=3).
// The directed steps come first. After them, random rounds are checked against
// a transaction-level model: the burst order follows from the priority and
// round-robin rules, and the expected writes are the in-range beats of each
// burst, taken in that order.
module tb_term_write_arbiter;

  localparam int COLS = 4;
  localparam int ROWS = 3;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] v;
    logic [5:0] ch;
    logic       last;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       req_valid [3];
  logic [7:0] req_h     [3];
  logic [7:0] req_v     [3];
  logic [5:0] req_char  [3];
  logic       req_last  [3];
  logic       req_ready [3];
  logic       clear_req;
  logic [7:0] w_h_addr;
  logic [7:0] w_v_addr;
  logic [5:0] w_data;
  logic       w_en;
  logic       busy;
  logic       clear_done;
  logic       err_oob;

  int    n_cmp;
  int    n_fail;
  int    cyc;
  beat_t bq    [3][$];
  beat_t bl    [3][$];
  beat_t wq    [$];
  int    wcyc  [$];
  int    dcyc  [$];
  beat_t exp_q [$];
  int    order [$];
  int    model_rr;
  logic  model_err;

  term_write_arbiter #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req_valid[0]),
    .req0_h     (req_h[0]),
    .req0_v     (req_v[0]),
    .req0_char  (req_char[0]),
    .req0_last  (req_last[0]),
    .req0_ready (req_ready[0]),
    .req1_valid (req_valid[1]),
    .req1_h     (req_h[1]),
    .req1_v     (req_v[1]),
    .req1_char  (req_char[1]),
    .req1_last  (req_last[1]),
    .req1_ready (req_ready[1]),
    .req2_valid (req_valid[2]),
    .req2_h     (req_h[2]),
    .req2_v     (req_v[2]),
    .req2_char  (req_char[2]),
    .req2_last  (req_last[2]),
    .req2_ready (req_ready[2]),
    .clear_req  (clear_req),
    .w_h_addr   (w_h_addr),
    .w_v_addr   (w_v_addr),
    .w_data     (w_data),
    .w_en       (w_en),
    .busy       (busy),
    .clear_done (clear_done),
    .err_oob    (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write and clear-done monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      wq.push_back('{h: w_h_addr, v: w_v_addr, ch: w_data, last: 1'b0});
      wcyc.push_back(cyc);
    end
    if (clear_done === 1'b1) dcyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    wq.delete();
    wcyc.delete();
    dcyc.delete();
  endtask

  function automatic beat_t mk(input int h, input int v, input int ch, input bit last);
    beat_t b;
    b.h = 8'(h);
    b.v = 8'(v);
    b.ch = 6'(ch);
    b.last = last;
    return b;
  endfunction

  // Present requester n's queued beats back to back, holding each until accepted.
  task automatic drive(input int n);
    beat_t b;
    int    guard;
    while (bq[n].size() > 0) begin
      b = bq[n].pop_front();
      req_valid[n] = 1'b1;
      req_h[n]     = b.h;
      req_v[n]     = b.v;
      req_char[n]  = b.ch;
      req_last[n]  = b.last;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (req_ready[n] !== 1'b1 && guard < 300);
      if (req_ready[n] !== 1'b1) begin
        check($sformatf("accept_timeout_req%0d", n), {31'd0, req_ready[n]}, 32'd1);
        bq[n].delete();
      end else begin
        @(posedge clk);
        #1;
      end
    end
    req_valid[n] = 1'b0;
    req_last[n]  = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 200 && dcyc.size() < n; i++) tick();
    check("clear_done_timeout", dcyc.size(), n);
  endtask

  task automatic check_data_seq(input string tag, input int exp_data [$]);
    check({tag, "_count"}, wq.size(), exp_data.size());
    for (int i = 0; i < wq.size() && i < exp_data.size(); i++)
      check($sformatf("%s_data%0d", tag, i), wq[i].ch, exp_data[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [2:0] mask;
    beat_t b;
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    rst = 1'b1;
    clear_req = 1'b0;
    for (int n = 0; n < 3; n++) begin
      req_valid[n] = 1'b0;
      req_h[n] = '0;
      req_v[n] = '0;
      req_char[n] = '0;
      req_last[n] = 1'b0;
    end

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check("rst_w_en", w_en, 0);
    check("rst_addr", {w_h_addr, w_v_addr, 2'b00, w_data}, 0);
    check("rst_busy", busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_err_oob", err_oob, 0);
    check("rst_ready", {req_ready[0], req_ready[1], req_ready[2]}, 0);
    tick();
    rst = 1'b0;

    // req0 three-beat burst with cycle-exact timing.
    req_valid[0] = 1'b1; req_h[0] = 8'd0; req_v[0] = 8'd0; req_char[0] = 6'd18; req_last[0] = 1'b0;
    @(negedge clk);
    check("a_grant_cycle_ready", req_ready[0], 0);
    tick();
    @(negedge clk);
    check("a_ready", req_ready[0], 1);
    check("a_busy", busy, 1);
    tick();
    req_v[0] = 8'd1;
    @(negedge clk);
    check("a_w0", {w_en, w_h_addr, w_v_addr, w_data}, {1'b1, 8'd0, 8'd0, 6'd18});
    tick();
    req_v[0] = 8'd2; req_last[0] = 1'b1;
    @(negedge clk);
    check("a_w1", {w_en, w_h_addr, w_v_addr, w_data}, {1'b1, 8'd0, 8'd1, 6'd18});
    tick();
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    @(negedge clk);
    check("a_w2", {w_en, w_h_addr, w_v_addr, w_data}, {1'b1, 8'd0, 8'd2, 6'd18});
    check("a_idle", {busy, req_ready[0]}, 0);
    tick();
    @(negedge clk);
    check("a_quiet_hold", {w_en, w_h_addr, w_v_addr, w_data}, {1'b0, 8'd0, 8'd2, 6'd18});
    tick();

    // req1/req2 continuously valid with single-beat bursts: grants alternate.
    flush();
    bq[1] = '{mk(0, 0, 1, 1), mk(1, 0, 1, 1)};
    bq[2] = '{mk(2, 0, 2, 1), mk(3, 0, 2, 1)};
    fork
      drive(1);
      drive(2);
    join
    repeat (3) tick();
    check_data_seq("b_rr", '{1, 2, 1, 2});

    // req0 raised mid req1 burst: req1 finishes, then req0 goes ahead of req2.
    flush();
    bq[1] = '{mk(0, 1, 1, 0), mk(1, 1, 1, 0), mk(2, 1, 1, 1)};
    bq[2] = '{mk(3, 1, 2, 1)};
    bq[0] = '{mk(0, 2, 3, 1)};
    fork
      drive(1);
      drive(2);
      begin
        repeat (2) tick();
        drive(0);
      end
    join
    repeat (3) tick();
    check_data_seq("b_prio", '{1, 1, 1, 3, 2});

    // Clear from IDLE, with a second request during CLEAR absorbed.
    flush();
    pulse_clear();
    repeat (2) tick();
    pulse_clear();
    wait_done(1);
    repeat (20) tick();
    check("c_count", wq.size(), COLS * ROWS);
    for (int i = 0; i < wq.size() && i < COLS * ROWS; i++) begin
      check($sformatf("c_cell%0d", i), {wq[i].h, wq[i].v, wq[i].ch}, {8'(i % COLS), 8'(i / COLS), 6'd0});
      check($sformatf("c_cyc%0d", i), wcyc[i], wcyc[0] + i);
    end
    check("c_done_count", dcyc.size(), 1);
    if (dcyc.size() > 0 && wcyc.size() > 0)
      check("c_done_cycle", dcyc[0], wcyc[wcyc.size() - 1] + 1);

    // Clear request during a 4-beat req2 burst waits for the burst to finish.
    flush();
    for (int i = 0; i < 4; i++) bq[2].push_back(mk(i, 2, 9, i == 3));
    fork
      drive(2);
      begin
        for (int i = 0; i < 50 && req_ready[2] !== 1'b1; i++) @(negedge clk);
        @(posedge clk);
        #1;
        pulse_clear();
      end
    join
    wait_done(1);
    repeat (5) tick();
    check("d_count", wq.size(), 4 + COLS * ROWS);
    if (wq.size() == 4 + COLS * ROWS) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("d_burst%0d", i), {wq[i].h, wq[i].v, wq[i].ch}, {8'(i), 8'd2, 6'd9});
      check("d_clear_first", {wq[4].h, wq[4].v, wq[4].ch}, 0);
      check("d_clear_last", {wq[15].h, wq[15].v, wq[15].ch}, {8'(COLS - 1), 8'(ROWS - 1), 6'd0});
      check("d_clear_gap", wcyc[4], wcyc[3] + 2);
    end

    // Out-of-range beat: consumed, no write, sticky error flag.
    check("e_err_before", err_oob, 0);
    flush();
    bq[1] = '{mk(COLS, 0, 5, 1)};
    drive(1);
    repeat (3) tick();
    check("e_no_write", wq.size(), 0);
    check("e_err_set", err_oob, 1);
    bq[2] = '{mk(1, 1, 7, 1)};
    drive(2);
    repeat (3) tick();
    check("e_later_write", wq.size(), 1);
    check("e_err_sticky", err_oob, 1);

    // Reset at the fifth clear write aborts everything.
    flush();
    pulse_clear();
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 5; i++) begin
      @(negedge clk);
      if (w_en === 1'b1) cnt++;
    end
    check("f_reached_write5", cnt, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("f_rst_outputs", {w_en, busy, err_oob, clear_done}, 0);
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("f_no_more_writes", wq.size(), 5);
    check("f_no_done", dcyc.size(), 0);
    flush();
    bq[1] = '{mk(0, 0, 1, 1)};
    bq[2] = '{mk(1, 0, 2, 1)};
    fork
      drive(1);
      drive(2);
    join
    repeat (3) tick();
    check_data_seq("f_rr_reset", '{1, 2});

    // Random rounds against the transaction-level model.
    flush();
    exp_q.delete();
    model_rr = 1;
    model_err = 1'b0;
    for (int r = 0; r < 30; r++) begin
      mask = 3'($urandom_range(1, 7));
      for (int n = 0; n < 3; n++) begin
        bl[n].delete();
        if (mask[n]) begin
          int nb;
          nb = $urandom_range(1, 4);
          for (int k = 0; k < nb; k++) begin
            b.h    = 8'($urandom_range(0, COLS));
            b.v    = ($urandom_range(0, 7) == 0) ? 8'(ROWS) : 8'($urandom_range(0, ROWS - 1));
            b.ch   = 6'($urandom_range(0, 63));
            b.last = (k == nb - 1);
            bl[n].push_back(b);
            bq[n].push_back(b);
          end
        end
      end
      order.delete();
      if (mask[0]) order.push_back(0);
      if (mask[1] && mask[2]) begin
        order.push_back(model_rr);
        order.push_back(3 - model_rr);
      end else if (mask[1]) begin
        order.push_back(1);
      end else if (mask[2]) begin
        order.push_back(2);
      end
      foreach (order[k]) begin
        if (order[k] == 1) model_rr = 2;
        if (order[k] == 2) model_rr = 1;
        foreach (bl[order[k]][j]) begin
          b = bl[order[k]][j];
          if (b.h < COLS && b.v < ROWS) begin
            b.last = 1'b0;
            exp_q.push_back(b);
          end else begin
            model_err = 1'b1;
          end
        end
      end
      fork
        drive(0);
        drive(1);
        drive(2);
      join
      repeat (3) tick();
      check($sformatf("rnd_err_oob_r%0d", r), err_oob, model_err);
    end
    check("rnd_count", wq.size(), exp_q.size());
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      check($sformatf("rnd_wr%0d", i), {wq[i].h, wq[i].v, wq[i].ch}, {exp_q[i].h, exp_q[i].v, exp_q[i].ch});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
